// File: rtl/apb_regfile_completer.sv
// APB completer fronting an 8-word register file: words 0-6 read/write, word 7 a read-only ID.
// Each transfer is stretched by WAIT_STATES access cycles. Errored transfers are counted.
module apb_regfile_completer #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslverr,
    output logic [7:0]            err_cnt,
    output logic [1:0]            o_state
);

    // Handshake: a setup edge (psel=1, penable=0) captures the request. Each later edge
    // with psel=1, penable=1 counts down the wait states. The edge that finds the counter
    // at zero completes the transfer, so pready is high for exactly one cycle. psel=0
    // during the access phase abandons the transfer without any side effect.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] RO_WORD = DATA_WIDTH'(32'hA9B0_0001);
    localparam logic [3:0]            LP_WAIT = 4'(WAIT_STATES);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_regs [0:6];
    logic                  r_pready;
    logic                  r_pslverr;
    logic [DATA_WIDTH-1:0] r_prdata;
    logic [7:0]            r_err_cnt;

    logic                  w_setup;
    logic                  w_capture;
    logic                  w_count;
    logic                  w_complete;
    logic                  w_err;
    logic                  w_wr_en;
    logic [2:0]            w_idx;
    logic [DATA_WIDTH-1:0] w_rd_val;

    assign w_setup = psel & ~penable;

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_count     = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_setup) begin
                    w_state_nxt = ST_ACCESS;
                    w_capture   = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (!psel) begin
                    w_state_nxt = ST_IDLE;
                end else if (penable) begin
                    if (r_cnt == 4'd0) begin
                        w_complete  = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_count = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (w_setup) begin
                    w_state_nxt = ST_ACCESS;
                    w_capture   = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Decode works only from the captured request, never from the live bus.
    always_comb begin
        w_idx    = r_addr[4:2];
        w_err    = (r_addr[1:0] != 2'b00) || (|r_addr[ADDR_WIDTH-1:5]) ||
                   (r_write && (w_idx == 3'd7));
        w_rd_val = RO_WORD;
        for (int i = 0; i < 7; i++) begin
            if (w_idx == 3'(i)) w_rd_val = r_regs[i];
        end
        w_wr_en  = w_complete && r_write && !w_err;
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_addr    <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
            r_err_cnt <= 8'd0;
            for (int i = 0; i < 7; i++) r_regs[i] <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pready  <= w_complete;
            r_pslverr <= w_complete && w_err;
            if (w_capture) begin
                r_addr  <= paddr;
                r_write <= pwrite;
                r_wdata <= pwdata;
                r_cnt   <= LP_WAIT;
            end else if (w_count) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_complete) r_prdata <= (r_write || w_err) ? '0 : w_rd_val;
            if (w_complete && w_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
            for (int i = 0; i < 7; i++) begin
                if (w_wr_en && (w_idx == 3'(i))) r_regs[i] <= r_wdata;
            end
        end
    end

    assign pready  = r_pready;
    assign pslverr = r_pslverr;
    assign prdata  = r_prdata;
    assign err_cnt = r_err_cnt;
    assign o_state = r_state;

endmodule

// File: tb/tb_apb_regfile_completer.sv
// Directed and random APB transfers against a word-array reference model of the register file.
module tb_apb_regfile_completer;

    localparam int          WS      = 2;
    localparam logic [31:0] RO_WORD = 32'hA9B0_0001;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic [7:0]  err_cnt;
    logic [1:0]  o_state;

    apb_regfile_completer #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .WAIT_STATES(WS)
    ) dut (
        .pclk   (pclk),
        .presetn(presetn),
        .psel   (psel),
        .penable(penable),
        .pwrite (pwrite),
        .paddr  (paddr),
        .pwdata (pwdata),
        .pready (pready),
        .prdata (prdata),
        .pslverr(pslverr),
        .err_cnt(err_cnt),
        .o_state(o_state)
    );

    always #5 pclk = ~pclk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [0:6];
    int          exp_err_cnt;
    logic [31:0] last_rd;
    logic [32:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 7; i++) mem[i] = '0;
        exp_err_cnt = 0;
        last_rd     = '0;
    endtask

    // Reference behaviour of one completed transfer; pushes {pslverr, prdata}.
    task automatic model_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        logic        err;
        logic [31:0] rd;
        err = (addr % 4 != 0) || (addr > 32'h1F) || (wr && addr == 32'h1C);
        rd  = '0;
        if (!err) begin
            if (wr) mem[addr / 4] = wd;
            else    rd = (addr == 32'h1C) ? RO_WORD : mem[addr / 4];
        end
        if (err && exp_err_cnt < 255) exp_err_cnt++;
        exp_q.push_back({err, rd});
    endtask

    // Full transfer; leaves psel/penable high so the caller can idle or go back-to-back.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input string tag);
        logic [32:0] exp;
        int          edges;
        model_xfer(wr, addr, wd);
        exp     = exp_q.pop_front();
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wd;
        @(posedge pclk); #1;
        check($sformatf("%s_setup_rdy", tag), {31'b0, pready}, 32'd0);
        check($sformatf("%s_setup_err", tag), {31'b0, pslverr}, 32'd0);
        check($sformatf("%s_setup_hold", tag), prdata, last_rd);
        paddr   = $urandom;
        pwdata  = $urandom;
        penable = 1'b1;
        edges   = 0;
        while (edges < 20) begin
            @(posedge pclk); #1;
            edges++;
            if (pready) break;
        end
        check($sformatf("%s_latency", tag), 32'(edges), 32'(WS + 1));
        check($sformatf("%s_slverr", tag), {31'b0, pslverr}, {31'b0, exp[32]});
        check($sformatf("%s_prdata", tag), prdata, exp[31:0]);
        check($sformatf("%s_errcnt", tag), {24'b0, err_cnt}, 32'(exp_err_cnt));
        last_rd = exp[31:0];
    endtask

    task automatic idle(input string tag);
        psel    = 1'b0;
        penable = 1'b0;
        @(posedge pclk); #1;
        check($sformatf("%s_idle_rdy", tag), {31'b0, pready}, 32'd0);
        check($sformatf("%s_idle_err", tag), {31'b0, pslverr}, 32'd0);
        check($sformatf("%s_idle_hold", tag), prdata, last_rd);
    endtask

    initial begin
        logic [31:0] a;
        logic        wr;
        int          cnt_before;
        presetn = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        model_reset();
        repeat (3) @(posedge pclk);
        #1;
        check("rst_pready", {31'b0, pready}, 32'd0);
        check("rst_pslverr", {31'b0, pslverr}, 32'd0);
        check("rst_prdata", prdata, 32'd0);
        check("rst_errcnt", {24'b0, err_cnt}, 32'd0);
        check("rst_state", {30'b0, o_state}, 32'd0);
        presetn = 1'b1;

        // penable without a setup phase must not start a transfer
        psel    = 1'b1;
        penable = 1'b1;
        paddr   = 32'h4;
        repeat (3) begin
            @(posedge pclk); #1;
            check("noset_rdy", {31'b0, pready}, 32'd0);
            check("noset_state", {30'b0, o_state}, 32'd0);
        end
        idle("noset");

        xfer(1'b0, 32'h04, 32'h0, "rd04");
        idle("rd04");

        xfer(1'b1, 32'h08, 32'hDEAD_BEEF, "wr08");
        xfer(1'b0, 32'h08, 32'h0, "rd08_b2b");
        idle("rd08");

        xfer(1'b0, 32'h1C, 32'h0, "rd1c");
        xfer(1'b1, 32'h1C, 32'h0, "wr1c");
        xfer(1'b0, 32'h1C, 32'h0, "rd1c_again");
        idle("ro");

        xfer(1'b0, 32'h06, 32'h0, "rd06");
        xfer(1'b0, 32'h40, 32'h0, "rd40");
        idle("errs");
        check("errcnt_three", {24'b0, err_cnt}, 32'd3);

        // abandoned write: psel drops after the first access edge
        cnt_before = exp_err_cnt;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h0C;
        pwdata  = 32'h1234_5678;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        check("abort_acc_rdy", {31'b0, pready}, 32'd0);
        psel    = 1'b0;
        penable = 1'b0;
        repeat (4) begin
            @(posedge pclk); #1;
            check("abort_rdy", {31'b0, pready}, 32'd0);
            check("abort_err", {31'b0, pslverr}, 32'd0);
        end
        check("abort_state", {30'b0, o_state}, 32'd0);
        check("abort_errcnt", {24'b0, err_cnt}, 32'(cnt_before));
        xfer(1'b0, 32'h0C, 32'h0, "rd0c_after_abort");
        idle("abort");

        for (int n = 0; n < 150; n++) begin
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 8) a = 32'($urandom_range(0, 7)) * 4;
            else if ($urandom_range(0, 1) == 1) a = 32'($urandom_range(0, 31));
            else a = $urandom;
            xfer(wr, a, $urandom, "rand");
            if ($urandom_range(0, 1) == 1) idle("rand");
        end
        idle("rand_end");

        // reset in the middle of a write to 0x10
        xfer(1'b0, 32'h1C, 32'h0, "pre_rst_rd");
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h10;
        pwdata  = 32'hFFFF_FFFF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        presetn = 1'b0;
        @(posedge pclk); #1;
        model_reset();
        check("midrst_pready", {31'b0, pready}, 32'd0);
        check("midrst_pslverr", {31'b0, pslverr}, 32'd0);
        check("midrst_prdata", prdata, 32'd0);
        check("midrst_errcnt", {24'b0, err_cnt}, 32'd0);
        check("midrst_state", {30'b0, o_state}, 32'd0);
        presetn = 1'b1;
        xfer(1'b0, 32'h10, 32'h0, "rd10_after_rst");
        xfer(1'b0, 32'h08, 32'h0, "rd08_after_rst");
        idle("post_rst");

        for (int n = 0; n < 260; n++) begin
            a = (32'($urandom_range(0, 7)) * 4) | 32'($urandom_range(1, 3));
            if (n % 3 == 0) a = 32'h20 + 32'($urandom_range(0, 1000)) * 4;
            xfer(1'($urandom_range(0, 1)), a, $urandom, "sat");
        end
        idle("sat");
        check("errcnt_saturated", {24'b0, err_cnt}, 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_regfile_completer.md
APB_REGFILE_COMPLETER -- requirements
Module: apb_regfile_completer

Interface
REQ-001 Parameter ADDR_WIDTH, 32, width of paddr SHALL apply.
REQ-002 Parameter DATA_WIDTH, 32, width of pwdata/prdata SHALL apply.
REQ-003 Parameter WAIT_STATES, 2, number of access-phase cycles with pready low SHALL apply; legal range 0-15.
REQ-004 pclk  input  1  SHALL be the sole clock; all logic on rising edge.
REQ-005 presetn  input  1  SHALL be the reset: synchronous, active-low.
REQ-006 psel  input  1  SHALL indicate completer selected.
REQ-007 penable  input  1  SHALL indicate access phase.
REQ-008 pwrite  input  1  SHALL mark a transfer as write (1) or read (0).
REQ-009 paddr  input  ADDR_WIDTH  SHALL be the byte address.
REQ-010 pwdata  input  DATA_WIDTH  SHALL be the write data.
REQ-011 pready  output  1  SHALL mark transfer completion; registered.
REQ-012 prdata  output  DATA_WIDTH  SHALL carry read data; registered.
REQ-013 pslverr  output  1  SHALL flag an errored transfer; valid only with pready; registered.
REQ-014 err_cnt  output  8  SHALL be the saturating count of pslverr responses.

Function
REQ-015 Register map SHALL be 8 words, index = paddr[4:2]; offsets 0x00-0x18 (regs 0-6) read/write; 0x1C (reg 7) read-only, constant 32'hA9B0_0001.
REQ-016 Error SHALL be raised when: paddr[1:0] != 0; any paddr bit above bit 4 is set; or a write targets 0x1C.
REQ-017 FSM SHALL have states IDLE, ACCESS, DONE.
REQ-018 IDLE: edge sampling psel=1, penable=0 (setup) SHALL capture paddr/pwrite/pwdata, load counter with WAIT_STATES, and go to ACCESS; penable=1 seen in IDLE SHALL be ignored.
REQ-019 ACCESS: at each edge with psel=1, penable=1 and counter != 0, the counter SHALL decrement, and pready SHALL stay 0.
REQ-020 ACCESS: at an edge with psel=1, penable=1 and counter == 0, the block SHALL set pready=1, set pslverr to the error flag, set prdata (register value for a good read, 0 for a write or error), perform a good write, and go to DONE.
REQ-021 With WAIT_STATES=0, pready SHALL rise after the first access-phase edge; in general after access edge WAIT_STATES+1.
REQ-022 DONE: the next edge SHALL clear pready and pslverr; prdata SHALL hold its value; the FSM SHALL go to IDLE, or directly to ACCESS (capturing as in REQ-018) if that edge samples a new setup.
REQ-023 pready SHALL be high for exactly one cycle per completed transfer.
REQ-024 psel=0 sampled in ACCESS SHALL abort the transfer: go to IDLE, no write, no pready, no pslverr, no err_cnt change.
REQ-025 Errored writes SHALL leave all registers unchanged; errored reads SHALL return prdata=0.
REQ-026 err_cnt SHALL increment on each edge that sets pslverr=1, and SHALL saturate at 255.
REQ-027 Captured address/data SHALL be used for the response; changes on paddr/pwdata during ACCESS SHALL be ignored.

Reset
REQ-028 presetn=0 at an edge SHALL force: FSM to IDLE, pready=0, pslverr=0, prdata=0, err_cnt=0, regs 0-6 to 0, counter to 0.
REQ-029 Reset SHALL take priority over any transfer in progress; the aborted transfer SHALL perform no write.
REQ-030 A setup sampled on the first edge after presetn returns high SHALL be accepted.

Verification
REQ-031 After reset with WAIT_STATES=2, read 0x04 -> pready low for 2 access edges then high 1 cycle; prdata=0, pslverr=0.
REQ-032 Write 0x08=32'hDEAD_BEEF, then read 0x08 -> prdata=32'hDEAD_BEEF, pslverr=0; back-to-back setup during DONE is accepted with no idle cycle.
REQ-033 Read 0x1C -> 32'hA9B0_0001; write 0x1C=0 -> pslverr=1, err_cnt=1; reread 0x1C -> 32'hA9B0_0001.
REQ-034 Read 0x06 and read 0x40 -> pslverr=1, prdata=0 each; err_cnt advances by 2; 260 errored transfers -> err_cnt=255.
REQ-035 Write 0x0C=32'h1234_5678 with psel dropped after the first access edge -> no pready; read 0x0C -> 0.
REQ-036 presetn=0 during ACCESS of a write to 0x10=32'hFFFF_FFFF -> all outputs 0 next cycle; read 0x10 after reset -> 0.
